// File: rtl/uart_pkg.sv
// AXI4-Lite request/response structs shared by the UART bridge and its bus peers.
package uart_pkg;

  typedef struct packed {
    logic [31:0] aw_addr;
    logic [2:0]  aw_prot;
    logic        aw_valid;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_valid;
    logic        b_ready;
    logic [31:0] ar_addr;
    logic [2:0]  ar_prot;
    logic        ar_valid;
    logic        r_ready;
  } axil_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    logic        b_valid;
    logic [1:0]  b_resp;
    logic        ar_ready;
    logic        r_valid;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
  } axil_resp_t;

endpackage

// File: rtl/uart_axil_bridge.sv
// UART byte-stream to AXI4-Lite initiator: decodes 'W'/'R' frames, issues one
// bus transaction per frame and streams back a status byte (plus read data).
module uart_axil_bridge #(
  parameter type         req_t          = uart_pkg::axil_req_t,
  parameter type         resp_t         = uart_pkg::axil_resp_t,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk_i,
  input  logic       arst_ni,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output req_t       req_o,
  input  resp_t      resp_i,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_ADDR, S_GET_DATA, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_SEND
  } state_t;

  state_t                  r_state, w_next;
  logic                    r_is_wr;
  logic [1:0]              r_cnt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_aw_valid, r_w_valid, r_ar_valid;
  logic [31:0]             r_buf;
  logic [2:0]              r_len;
  logic                    r_tx_valid;
  logic [7:0]              r_tx_data;
  logic [31:0]             r_tmo;

  logic w_rx_hs, w_tx_hs, w_collect, w_tmo, w_known, w_aw_done, w_w_done;

  assign w_collect  = (r_state == S_GET_ADDR) || (r_state == S_GET_DATA);
  assign rx_ready_o = (r_state == S_IDLE) || w_collect;
  assign w_rx_hs    = rx_valid_i && rx_ready_o;
  assign w_tx_hs    = r_tx_valid && tx_ready_i;
  assign w_known    = (rx_data_i == 8'h57) || (rx_data_i == 8'h52);
  assign w_tmo      = (TIMEOUT_CYCLES != 0) && w_collect && (r_tmo == TIMEOUT_CYCLES);
  assign w_aw_done  = !r_aw_valid || resp_i.aw_ready;
  assign w_w_done   = !r_w_valid  || resp_i.w_ready;
  assign busy_o     = (r_state != S_IDLE);
  assign tx_valid_o = r_tx_valid;
  assign tx_data_o  = r_tx_data;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // An accepted byte wins over a timeout landing in the same cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_rx_hs) w_next = w_known ? S_GET_ADDR : S_SEND;
      S_GET_ADDR: if (w_rx_hs) begin
                    if (r_cnt == 2'd3) w_next = r_is_wr ? S_GET_DATA : S_RD_REQ;
                  end else if (w_tmo) w_next = S_IDLE;
      S_GET_DATA: if (w_rx_hs) begin
                    if (r_cnt == 2'd3) w_next = S_WR_REQ;
                  end else if (w_tmo) w_next = S_IDLE;
      S_WR_REQ:   if (w_aw_done && w_w_done) w_next = S_WR_RESP;
      S_WR_RESP:  if (resp_i.b_valid) w_next = S_SEND;
      S_RD_REQ:   if (resp_i.ar_ready) w_next = S_RD_RESP;
      S_RD_RESP:  if (resp_i.r_valid) w_next = S_SEND;
      S_SEND:     if (w_tx_hs && (r_len == 3'd0)) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_is_wr    <= 1'b0;
      r_cnt      <= 2'd0;
      r_addr     <= '0;
      r_data     <= '0;
      r_aw_valid <= 1'b0;
      r_w_valid  <= 1'b0;
      r_ar_valid <= 1'b0;
      r_buf      <= '0;
      r_len      <= 3'd0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
      r_tmo      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= 2'd0;
          r_tmo <= '0;
          if (w_rx_hs) begin
            r_is_wr <= (rx_data_i == 8'h57);
            if (!w_known) begin
              r_tx_valid <= 1'b1;
              r_tx_data  <= 8'hEE;
              r_len      <= 3'd0;
            end
          end
        end
        // The 2-bit counter wraps to 0 on the 4th byte, so it is clear on entry to GET_DATA.
        S_GET_ADDR, S_GET_DATA: begin
          if (w_rx_hs) begin
            r_cnt <= r_cnt + 2'd1;
            r_tmo <= '0;
            if (r_state == S_GET_ADDR) r_addr <= {rx_data_i, r_addr[ADDR_WIDTH-1:8]};
            else                       r_data <= {rx_data_i, r_data[DATA_WIDTH-1:8]};
            if (r_cnt == 2'd3) begin
              if (r_state == S_GET_DATA) begin
                r_aw_valid <= 1'b1;
                r_w_valid  <= 1'b1;
              end else if (!r_is_wr) begin
                r_ar_valid <= 1'b1;
              end
            end
          end else begin
            r_tmo <= r_tmo + 32'd1;
          end
        end
        S_WR_REQ: begin
          if (resp_i.aw_ready) r_aw_valid <= 1'b0;
          if (resp_i.w_ready)  r_w_valid  <= 1'b0;
        end
        S_WR_RESP: if (resp_i.b_valid) begin
          r_tx_valid <= 1'b1;
          r_tx_data  <= 8'hA0 | {6'd0, resp_i.b_resp};
          r_len      <= 3'd0;
        end
        S_RD_REQ: if (resp_i.ar_ready) r_ar_valid <= 1'b0;
        S_RD_RESP: if (resp_i.r_valid) begin
          r_tx_valid <= 1'b1;
          r_tx_data  <= 8'hA0 | {6'd0, resp_i.r_resp};
          r_buf      <= resp_i.r_data;
          r_len      <= 3'd4;
        end
        S_SEND: if (w_tx_hs) begin
          if (r_len == 3'd0) begin
            r_tx_valid <= 1'b0;
          end else begin
            r_tx_data <= r_buf[7:0];
            r_buf     <= {8'h00, r_buf[31:8]};
            r_len     <= r_len - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_o          = '0;
    req_o.aw_addr  = r_addr;
    req_o.aw_valid = r_aw_valid;
    req_o.w_data   = r_data;
    req_o.w_strb   = 4'hF;
    req_o.w_valid  = r_w_valid;
    req_o.b_ready  = (r_state == S_WR_RESP);
    req_o.ar_addr  = r_addr;
    req_o.ar_valid = r_ar_valid;
    req_o.r_ready  = (r_state == S_RD_RESP);
  end

endmodule

// File: tb/tb_uart_axil_bridge.sv
// Directed bench for uart_axil_bridge with a small behavioural AXI-Lite responder.
module tb_uart_axil_bridge;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       arst_ni = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       busy;
  axil_req_t  req;
  axil_resp_t resp = '0;

  always #5 clk = ~clk;

  uart_axil_bridge #(.TIMEOUT_CYCLES(50)) dut (
    .clk_i(clk), .arst_ni(arst_ni),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .req_o(req), .resp_i(resp), .busy_o(busy)
  );

  int n_tests = 0, n_fail = 0;
  int n_aw = 0, n_w = 0, n_ar = 0, vcyc = 0;
  logic [31:0] cap_aw = '0, cap_w = '0, cap_ar = '0;
  logic [3:0]  cap_strb = '0;
  logic [2:0]  cap_prot = '0;
  bit aw_got = 0, w_got = 0, ar_got = 0;
  int aw_cnt = 0, aw_delay = 0;
  logic [1:0]  b_resp_v = 2'd0, r_resp_v = 2'd0;
  logic [31:0] rdata_v = '0;
  logic [7:0]  txq[$];

  // Responder drives its outputs on the falling edge, records handshakes on the rising edge.
  always @(negedge clk) begin
    resp.aw_ready = req.aw_valid && (aw_cnt >= aw_delay);
    if (req.aw_valid && !resp.aw_ready) aw_cnt++;
    resp.w_ready  = req.w_valid;
    resp.ar_ready = req.ar_valid;
    resp.b_valid  = aw_got && w_got;
    resp.b_resp   = b_resp_v;
    resp.r_valid  = ar_got;
    resp.r_data   = rdata_v;
    resp.r_resp   = r_resp_v;
  end

  always @(posedge clk) begin
    if (!arst_ni) begin
      aw_got = 0; w_got = 0; ar_got = 0; aw_cnt = 0;
    end else begin
      if (req.aw_valid || req.w_valid || req.ar_valid) vcyc++;
      if (req.aw_valid && resp.aw_ready) begin
        n_aw++; cap_aw = req.aw_addr; cap_prot = req.aw_prot; aw_got = 1; aw_cnt = 0;
      end
      if (req.w_valid && resp.w_ready) begin
        n_w++; cap_w = req.w_data; cap_strb = req.w_strb; w_got = 1;
      end
      if (req.ar_valid && resp.ar_ready) begin
        n_ar++; cap_ar = req.ar_addr; ar_got = 1;
      end
      if (resp.b_valid && req.b_ready) begin aw_got = 0; w_got = 0; end
      if (resp.r_valid && req.r_ready) ar_got = 0;
      if (tx_valid && tx_ready) txq.push_back(tx_data);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1;
    while (!rx_ready && k < 500) begin @(negedge clk); k++; end
    if (!rx_ready) chk("rx_accept", rx_ready, 1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [71:0] bytes);
    for (int i = 0; i < n; i++) send_byte(bytes[8*i +: 8]);
  endtask

  task automatic expect_tx(input string tag, input int n, input logic [39:0] exp);
    int k = 0;
    while (txq.size() < n && k < 300) begin @(negedge clk); k++; end
    repeat (5) @(negedge clk);
    chk({tag, "_len"}, txq.size(), n);
    for (int i = 0; i < n; i++)
      if (i < txq.size()) chk($sformatf("%s_b%0d", tag, i), txq[i], exp[8*i +: 8]);
    txq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, a0, bad;
    repeat (3) @(negedge clk);
    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_valids", {req.aw_valid, req.w_valid, req.ar_valid}, 3'b000);
    chk("rst_readies", {req.b_ready, req.r_ready}, 2'b00);
    arst_ni = 1'b1;

    // Write, AW ready delayed 3 cycles, W ready immediate
    aw_delay = 3; b_resp_v = 2'd0;
    send_frame(9, 72'hDE_AD_BE_EF_40_00_10_00_57);
    chk("wr_aw_valid_next", req.aw_valid, 1);
    chk("wr_w_valid_next", req.w_valid, 1);
    expect_tx("wr_ok", 1, 40'hA0);
    chk("wr_n_aw", n_aw, 1);
    chk("wr_n_w", n_w, 1);
    chk("wr_addr", cap_aw, 32'h4000_1000);
    chk("wr_data", cap_w, 32'hDEAD_BEEF);
    chk("wr_strb", cap_strb, 4'hF);
    chk("wr_prot", cap_prot, 3'd0);
    chk("wr_idle", busy, 0);
    aw_delay = 0;

    // Read OKAY
    rdata_v = 32'h1234_5678; r_resp_v = 2'd0;
    send_frame(5, 72'h40_00_10_04_52);
    chk("rd_ar_valid_next", req.ar_valid, 1);
    expect_tx("rd_ok", 5, 40'h12_34_56_78_A0);
    chk("rd_n_ar", n_ar, 1);
    chk("rd_addr", cap_ar, 32'h4000_1004);

    // Read SLVERR, unaligned address passed through
    rdata_v = 32'hCAFE_F00D; r_resp_v = 2'd2;
    send_frame(5, 72'h80_00_00_03_52);
    expect_tx("rd_slverr", 5, 40'hCA_FE_F0_0D_A2);
    chk("rd_slverr_addr", cap_ar, 32'h8000_0003);

    // Write DECERR
    b_resp_v = 2'd3;
    send_frame(9, 72'h01_02_03_04_00_00_00_20_57);
    expect_tx("wr_decerr", 1, 40'hA3);
    chk("wr_decerr_data", cap_w, 32'h0102_0304);
    b_resp_v = 2'd0;

    // Unknown command, then a valid read
    v0 = vcyc;
    send_byte(8'h33);
    expect_tx("bad_cmd", 1, 40'hEE);
    chk("bad_no_axi", vcyc, v0);
    rdata_v = 32'h0BAD_F00D; r_resp_v = 2'd0;
    send_frame(5, 72'h00_00_00_10_52);
    expect_tx("after_bad", 5, 40'h0B_AD_F0_0D_A0);
    chk("after_bad_addr", cap_ar, 32'h0000_0010);

    // Timeout drops a partial frame silently
    v0 = vcyc; a0 = n_aw;
    send_frame(3, 72'h10_00_57);
    chk("tmo_busy_mid", busy, 1);
    repeat (60) @(negedge clk);
    chk("tmo_idle", busy, 0);
    chk("tmo_no_axi", vcyc, v0);
    chk("tmo_no_aw", n_aw, a0);
    chk("tmo_no_tx", txq.size(), 0);
    rdata_v = 32'hA5A5_5A5A;
    send_frame(5, 72'h00_00_00_00_52);
    expect_tx("after_tmo", 5, 40'hA5_A5_5A_5A_A0);
    chk("after_tmo_addr", cap_ar, 32'h0000_0000);

    // Backpressure on the read reply
    tx_ready = 1'b0;
    rdata_v = 32'h1122_3344;
    send_frame(5, 72'h00_00_00_08_52);
    bad = 0;
    for (int k = 0; k < 100 && !tx_valid; k++) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      if (tx_data !== 8'hA0 || tx_valid !== 1'b1 || rx_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("bp_stable", bad, 0);
    chk("bp_nothing_sent", txq.size(), 0);
    tx_ready = 1'b1;
    expect_tx("bp_reply", 5, 40'h11_22_33_44_A0);

    // Reset mid-write abandons the transaction
    aw_delay = 1000;
    send_frame(9, 72'h55_55_55_55_00_00_00_30_57);
    repeat (3) @(negedge clk);
    chk("mid_aw_pending", req.aw_valid, 1);
    arst_ni = 1'b0;
    #1;
    chk("mid_rst_aw", req.aw_valid, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    arst_ni = 1'b1;
    aw_delay = 0;
    txq.delete();
    rdata_v = 32'h7654_3210;
    send_frame(5, 72'h00_00_00_0C_52);
    expect_tx("after_rst", 5, 40'h76_54_32_10_A0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
